// File: rtl/main_fsm_ctrl.sv
// Multicycle ARM-subset main controller: Moore state register with combinational
// strobe and ALU decode; strobes forced low while reset is held.
module main_fsm_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    state_e     state_q;
    logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op;
    logic [1:0] alu_ctrl, flag_w;
    logic       no_write;
    logic [3:0] cmd;
    logic       s_bit;

    assign cmd   = Funct[4:1];
    assign s_bit = Funct[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            unique case (state_q)
                StFetch:    if (MemReady) state_q <= StDecode;
                StDecode: begin
                    case (Op)
                        2'b00:   state_q <= Funct[5] ? StExecI : StExecR;
                        2'b01:   state_q <= StMemAdr;
                        2'b10:   state_q <= StBranch;
                        default: state_q <= StFetch;
                    endcase
                end
                StMemAdr:   state_q <= s_bit ? StMemRead : StMemWrite;
                StMemRead:  if (MemReady) state_q <= StMemWb;
                StMemWrite: if (MemReady) state_q <= StFetch;
                StExecR, StExecI: state_q <= StAluWb;
                default:    state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        ir_write  = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            StFetch: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = MemReady;
                next_pc   = MemReady;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr:   ALUSrcB = 2'b01;
            StMemRead:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            StMemWrite: begin
                AdrSrc = 1'b1;
                mem_w  = MemReady;
            end
            StExecR:    alu_op = 1'b1;
            StExecI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            StAluWb:    reg_w = 1'b1;
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Unrecognised commands execute as ADD but never write flags or the register file.
    always_comb begin
        alu_ctrl = 2'b00;
        flag_w   = 2'b00;
        no_write = 1'b0;
        if (alu_op) begin
            case (cmd)
                4'b0100: flag_w = {s_bit, s_bit};
                4'b0010: begin
                    alu_ctrl = 2'b01;
                    flag_w   = {s_bit, s_bit};
                end
                4'b0000: begin
                    alu_ctrl = 2'b10;
                    flag_w   = {s_bit, 1'b0};
                end
                4'b1100: begin
                    alu_ctrl = 2'b11;
                    flag_w   = {s_bit, 1'b0};
                end
                4'b1010: begin
                    alu_ctrl = 2'b01;
                    flag_w   = 2'b11;
                    no_write = 1'b1;
                end
                default: no_write = 1'b1;
            endcase
        end
    end

    assign IRWrite    = reset & ir_write;
    assign NextPC     = reset & next_pc;
    assign RegW       = reset & reg_w;
    assign MemW       = reset & mem_w;
    assign PCS        = reset & ((reg_w & (Rd == 4'hF)) | branch);
    assign FlagW      = reset ? flag_w : 2'b00;
    assign NoWrite    = reset & no_write;
    assign ALUControl = alu_ctrl;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
    assign State      = state_q;

endmodule

// File: tb/tb_main_fsm_ctrl.sv
// Bench for main_fsm_ctrl: table-driven reference model compared every negedge,
// plus directed instruction sequences with literal expectations.
module tb_main_fsm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;
    logic       IRWrite, NextPC, AdrSrc, RegW, MemW, PCS, NoWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;
    int m_state;

    main_fsm_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .RegW(RegW), .MemW(MemW), .PCS(PCS), .FlagW(FlagW),
        .NoWrite(NoWrite), .State(State)
    );

    always #5 clk = ~clk;

    // Per-state datapath selects, indexed by state number.
    int t_adr[10]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    int t_sa[10]   = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int t_sb[10]   = '{2, 2, 1, 0, 0, 0, 0, 1, 0, 1};
    int t_rs[10]   = '{2, 2, 0, 0, 1, 0, 0, 0, 0, 2};
    int t_regw[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    function automatic int model_next(int s, logic [1:0] op, logic [5:0] f, logic mr);
        if (s == 0) return mr ? 1 : 0;
        if (s == 1) begin
            if (op == 2'd1) return 2;
            if (op == 2'd2) return 9;
            if (op == 2'd0) return f[5] ? 7 : 6;
            return 0;
        end
        if (s == 2) return f[0] ? 3 : 5;
        if (s == 3) return mr ? 4 : 3;
        if (s == 5) return mr ? 0 : 5;
        if (s == 6 || s == 7) return 8;
        return 0;
    endfunction

    function automatic logic [24:0] model_out(int s, logic rn, logic [1:0] op, logic [5:0] f,
                                             logic [3:0] rd, logic mr);
        logic       ir, memw, regw, br, nw, pcs;
        logic [1:0] ac, fw;
        int         cmd;
        ir   = rn && s == 0 && mr;
        memw = rn && s == 5 && mr;
        regw = rn && t_regw[s] == 1;
        br   = rn && s == 9;
        cmd  = int'(f[4:1]);
        ac = 2'd0; fw = 2'd0; nw = 1'b0;
        if (s == 6 || s == 7) begin
            if (cmd == 4)       ac = 2'd0;
            else if (cmd == 2)  ac = 2'd1;
            else if (cmd == 0)  ac = 2'd2;
            else if (cmd == 12) ac = 2'd3;
            else if (cmd == 10) ac = 2'd1;
            if (cmd == 10) begin
                fw = 2'b11; nw = 1'b1;
            end else if (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12) begin
                fw = {f[0], f[0] && ac < 2'd2};
            end else begin
                nw = 1'b1;
            end
            if (!rn) begin
                fw = 2'd0; nw = 1'b0;
            end
        end
        pcs = (regw && rd == 4'd15) || br;
        return {ir, ir, t_adr[s] == 1, 2'(t_sa[s]), 2'(t_sb[s]), 2'(t_rs[s]), ac, op,
                op == 2'd1, op == 2'd2, regw, memw, pcs, fw, nw, 4'(s)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m_state <= 0;
        else        m_state <= model_next(m_state, Op, Funct, MemReady);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [24:0] dv, ev;
        dv = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc,
              RegSrc, RegW, MemW, PCS, FlagW, NoWrite, State};
        ev = model_out(m_state, reset, Op, Funct, Rd, MemReady);
        total++;
        if (dv !== ev) begin
            bad++;
            $display("FAIL model compare (state %0d): got %h expected %h", m_state, dv, ev);
        end
    end

    task automatic ng();
        @(negedge clk);
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dp(input logic [5:0] f, input logic [3:0] rd, input int ac, input int fw,
                          input int nw, input int pcs_wb);
        Op = 2'b00; Funct = f; Rd = rd; MemReady = 1'b1;
        ng(); chk("dp fetch state", int'(State), 0); chk("dp fetch IRWrite", int'(IRWrite), 1);
        nx();
        ng(); chk("dp decode state", int'(State), 1); nx();
        ng(); chk("dp exec state", int'(State), f[5] ? 7 : 6);
        chk("dp ALUControl", int'(ALUControl), ac);
        chk("dp FlagW", int'(FlagW), fw);
        chk("dp NoWrite", int'(NoWrite), nw);
        nx();
        ng(); chk("dp aluwb state", int'(State), 8); chk("dp aluwb RegW", int'(RegW), 1);
        chk("dp aluwb PCS", int'(PCS), pcs_wb);
        nx();
    endtask

    initial begin
        reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; MemReady = 1'b1;
        #2 reset = 1'b0;
        ng();
        chk("reset State", int'(State), 0);
        chk("reset IRWrite gated", int'(IRWrite), 0);
        chk("reset NextPC gated", int'(NextPC), 0);
        nx();
        reset = 1'b1;

        // Fetch stall
        MemReady = 1'b0;
        ng(); chk("stall state", int'(State), 0); chk("stall IRWrite", int'(IRWrite), 0); nx();
        ng(); chk("stall state 2", int'(State), 0); nx();

        run_dp(6'b001001, 4'd1,  0, 3, 0, 0);  // ADDS r1
        run_dp(6'b010101, 4'd0,  1, 3, 1, 0);  // CMP
        run_dp(6'b111010, 4'd15, 0, 0, 1, 1);  // MOV pc, #imm
        run_dp(6'b011001, 4'd3,  3, 2, 0, 0);  // ORRS
        run_dp(6'b000100, 4'd4,  1, 0, 0, 0);  // SUB
        run_dp(6'b100001, 4'd5,  2, 2, 0, 0);  // ANDS #imm

        // LDR with three wait cycles
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd2; MemReady = 1'b1;
        ng(); nx(); ng(); chk("ldr decode", int'(State), 1); nx();
        MemReady = 1'b0;
        ng(); chk("ldr memadr", int'(State), 2); nx();
        for (int i = 0; i < 3; i++) begin
            ng(); chk("ldr memread wait", int'(State), 3); nx();
        end
        MemReady = 1'b1;
        ng(); chk("ldr memread ready", int'(State), 3); nx();
        ng(); chk("ldr memwb", int'(State), 4); chk("ldr RegW", int'(RegW), 1);
        chk("ldr ResultSrc", int'(ResultSrc), 1); nx();

        // STR with Rd=15
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd15; MemReady = 1'b1;
        ng(); nx(); ng(); nx();
        MemReady = 1'b0;
        ng(); chk("str RegSrc", int'(RegSrc), 2); chk("str ImmSrc", int'(ImmSrc), 1); nx();
        ng(); chk("str memwrite", int'(State), 5); chk("str MemW wait", int'(MemW), 0); nx();
        MemReady = 1'b1;
        ng(); chk("str MemW ready", int'(MemW), 1); chk("str PCS", int'(PCS), 0); nx();
        ng(); chk("str back to fetch", int'(State), 0);

        // Branch
        Op = 2'b10; Funct = 6'b000000; Rd = 4'd0; MemReady = 1'b1;
        nx(); ng(); chk("b decode", int'(State), 1); chk("b RegSrc", int'(RegSrc), 1); nx();
        ng(); chk("b branch", int'(State), 9); chk("b PCS", int'(PCS), 1); nx();
        ng(); chk("b fetch", int'(State), 0);

        // Undefined op
        Op = 2'b11; Rd = 4'd15;
        nx(); ng(); chk("undef decode", int'(State), 1);
        chk("undef strobes", int'({IRWrite, NextPC, RegW, MemW, PCS, FlagW, NoWrite}), 0); nx();
        ng(); chk("undef fetch", int'(State), 0); nx();

        // Reset in the middle of a store
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd0; MemReady = 1'b1;
        ng(); nx(); ng(); nx();
        MemReady = 1'b0;
        ng(); nx();
        MemReady = 1'b1;
        #1 chk("rst pre MemW", int'(MemW), 1);
        reset = 1'b0;
        #1;
        chk("rst async MemW", int'(MemW), 0);
        chk("rst async State", int'(State), 0);
        chk("rst async IRWrite", int'(IRWrite), 0);
        nx(); nx();
        ng(); chk("rst held State", int'(State), 0);
        nx();
        reset = 1'b1; Op = 2'b11;
        ng(); chk("rel fetch", int'(State), 0); nx();
        ng(); chk("rel first edge", int'(State), 1); nx();
        ng(); chk("rel back", int'(State), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
